// File: rtl/spi_target.sv
// SPI mode-0 target. It synchronises sck/cs_n/mosi into clk, then shifts bytes
// in MSB-first on rising sck. It shifts a one-byte-buffered tx stream out on
// falling sck. The fabric side uses a byte-wide valid/ready handshake.
module spi_target #(
    parameter logic [7:0] IDLE_FILL = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state, state_n;

    // synchroniser stages; *_d is the extra edge-detect register
    logic       sck_m, sck_s, sck_d;
    logic       cs_m, cs_s, cs_d;
    logic       mosi_m, mosi_s;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] hold_data;
    logic       hold_full;

    logic       sck_rise, sck_fall, cs_fall, cs_rise;
    logic       sel_start, sel_end, load_tx, shift_tx, rx_step;

    // Two-stage synchronisers plus edge registers. The cs_n chain resets to 0
    // so a select already held low across reset is never taken as a fresh
    // fall. The block then waits for a real cs_n fall and never resumes
    // mid-byte. mosi has the same depth as sck_s, so the two stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_m  <= 1'b0;
            sck_s  <= 1'b0;
            sck_d  <= 1'b0;
            cs_m   <= 1'b0;
            cs_s   <= 1'b0;
            cs_d   <= 1'b0;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            sck_m  <= sck;
            sck_s  <= sck_m;
            sck_d  <= sck_s;
            cs_m   <= cs_n;
            cs_s   <= cs_m;
            cs_d   <= cs_s;
            mosi_m <= mosi;
            mosi_s <= mosi_m;
        end
    end

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;

    // select state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state, datapath strobes and pad outputs. A deselect suppresses any
    // sck edge that lands in the same cycle.
    always_comb begin
        state_n   = state;
        sel_start = 1'b0;
        sel_end   = 1'b0;
        load_tx   = 1'b0;
        shift_tx  = 1'b0;
        rx_step   = 1'b0;
        busy      = 1'b0;
        miso_oe   = 1'b0;
        miso      = 1'b1;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n   = ACTIVE;
                    sel_start = 1'b1;
                    load_tx   = 1'b1;
                end
            end
            ACTIVE: begin
                busy    = 1'b1;
                miso_oe = 1'b1;
                miso    = tx_shift[7];
                if (cs_rise) begin
                    state_n = IDLE;
                    sel_end = 1'b1;
                end else begin
                    rx_step = sck_rise;
                    if (sck_fall) begin
                        if (bit_cnt == 3'd0) load_tx  = 1'b1;
                        else                 shift_tx = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign tx_ready = ~hold_full;

    // Holding register, tx/rx shifters, bit counter and the one-cycle pulses.
    // An accept needs the holding register to be empty. A load that sees it
    // empty sends IDLE_FILL instead, so an accept and a drain never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            tx_shift    <= IDLE_FILL;
            hold_data   <= 8'h00;
            hold_full   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            if (load_tx) begin
                if (hold_full) begin
                    tx_shift  <= hold_data;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift    <= IDLE_FILL;
                    tx_underrun <= 1'b1;
                end
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[6:0], 1'b1};
            end

            if (sel_start || sel_end) begin
                bit_cnt <= 3'd0;
            end else if (rx_step) begin
                rx_shift <= {rx_shift[6:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data  <= {rx_shift[6:0], mosi_s};
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule
